// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux between four requesters, with a
// bounded hold time under contention and a registered select/grant.
//
// state | meaning
// IDLE  | no grant active, select lines keep their last value
// GRANT | one channel owns the mux; hold_q counts its consecutive cycles
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = 3
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       en_i,
  input  logic [3:0] req_i,
  input  logic       w0_i,
  input  logic       w1_i,
  input  logic       w2_i,
  input  logic       w3_i,
  output logic [3:0] gnt_o,
  output logic       valid_o,
  output logic       s1_o,
  output logic       s0_o,
  output logic       f_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state_q;
  logic [3:0]        gnt_q;
  logic              valid_q;
  logic [1:0]        sel_q;
  logic [1:0]        ptr_q;
  logic [HOLD_W-1:0] hold_q;

  logic [3:0] w_vec;
  logic [3:0] others;
  logic [1:0] win_idle;
  logic [1:0] win_rot;

  // Lowest offset from start with a set request wins (loop runs high to low).
  function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] res;
    res = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (req[idx]) res = idx;
    end
    return res;
  endfunction

  always_comb begin
    w_vec    = {w3_i, w2_i, w1_i, w0_i};
    others   = req_i & ~(4'b0001 << sel_q);
    win_idle = pick(req_i, ptr_q + 2'd1);
    win_rot  = pick(others, sel_q + 2'd1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      valid_q <= 1'b0;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd3;
      hold_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en_i && (req_i != 4'b0000)) begin
            state_q <= GRANT;
            gnt_q   <= 4'b0001 << win_idle;
            valid_q <= 1'b1;
            sel_q   <= win_idle;
            ptr_q   <= win_idle;
            hold_q  <= '0;
          end
        end
        GRANT: begin
          if (!en_i || (!req_i[sel_q] && (others == 4'b0000))) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            valid_q <= 1'b0;
            hold_q  <= '0;
          end else if (!req_i[sel_q] || ((hold_q == HOLD_LAST) && (others != 4'b0000))) begin
            // Owner released, or its hold expired while someone else waits.
            gnt_q   <= 4'b0001 << win_rot;
            sel_q   <= win_rot;
            ptr_q   <= win_rot;
            hold_q  <= '0;
          end else if (hold_q != HOLD_LAST) begin
            hold_q  <= hold_q + HOLD_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o   = gnt_q;
  assign valid_o = valid_q;
  assign s1_o    = sel_q[1];
  assign s0_o    = sel_q[0];
  assign f_o     = valid_q & w_vec[sel_q];

endmodule
